i2c_target: RTL and testbench

Synthesizable I2C target (responder) that answers the cfide I2C host controller's transactions. It replaces the behavioural slave model in benches and gives FPGA-side peripherals a byte-addressed register window. The block oversamples SCL/SDA on the system clock, detects START/STOP, matches a 7-bit address, and ACKs bytes. Writes set a register pointer and then store data with auto-increment; reads stream register contents out.

---
 rtl/i2c_target_pkg.sv | 27 ++
 rtl/i2c_target_if.sv | 19 +
 rtl/i2c_line_filter.sv | 46 ++++
 rtl/i2c_target.sv | 178 +++++++++++++++++
 tb/tb_i2c_target.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the I2C target.
// Imported by the target top and its testbench-facing views.
package i2c_target_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK,
    IGNORE
  } i2c_tgt_state_t;

  localparam int BITCNT_W = 4;

  localparam logic [BITCNT_W-1:0] BYTE_BITS = BITCNT_W'(8);
  localparam logic [BITCNT_W-1:0] LAST_BIT  = BITCNT_W'(7);
  localparam logic [BITCNT_W-1:0] FIRST_TX  = BITCNT_W'(1);

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

endpackage

// File: rtl/i2c_target_if.sv
// I2C pin bundle between a bus host and the target.
// sda_o is open-drain: 0 pulls low, 1 releases.
interface i2c_target_if;
  logic scl_i;
  logic sda_i;
  logic sda_o;

  modport master (
    output scl_i,
    output sda_i,
    input  sda_o
  );

  modport slave (
    input  scl_i,
    input  sda_i,
    output sda_o
  );
endinterface

// File: rtl/i2c_line_filter.sv
// Two-flop synchronizer, N-sample deglitcher and edge strobes
// for one I2C line; idles high.
module i2c_line_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic sysclk,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1;
  logic s2;
  logic [FILTER_LEN-2:0] hist;
  logic [FILTER_LEN-1:0] win;

  // s2 plus history forms the FILTER_LEN-sample window
  assign win = {hist, s2};

  always_ff @(posedge sysclk) begin
    if (reset) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      hist  <= '1;
      level <= 1'b1;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      s1   <= pin;
      s2   <= s1;
      hist <= win[FILTER_LEN-2:0];
      rise <= 1'b0;
      fall <= 1'b0;
      if ((&win) && !level) begin
        level <= 1'b1;
        rise  <= 1'b1;
      end else if (!(|win) && level) begin
        level <= 1'b0;
        fall  <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_target.sv
// I2C target with a byte-addressed register window:
// pointer write, auto-increment write and streaming read.
module i2c_target
  import i2c_target_pkg::*;
#(
  parameter logic [6:0] ADDR7      = 7'h39,
  parameter int         NREGS_LOG2 = 4,
  parameter int         FILTER_LEN = 3
) (
  input  logic                  sysclk,
  input  logic                  reset,
  i2c_target_if.slave           bus,
  input  logic [NREGS_LOG2-1:0] host_idx,
  output logic [7:0]            host_q,
  output logic [7:0]            wr_data,
  output logic [NREGS_LOG2-1:0] wr_idx,
  output logic                  wr_valid,
  output logic                  busy
);

  localparam int NREGS = 1 << NREGS_LOG2;

  logic [7:0] regs [NREGS];

  logic scl_f, scl_rise, scl_fall;
  logic sda_f, sda_rise, sda_fall;
  logic cond_start, cond_stop;
  logic rx_state;

  i2c_tgt_state_t        state;
  logic [BITCNT_W-1:0]   bitcnt;
  logic [7:0]            sr;
  logic [7:0]            tx;
  logic [7:0]            rx_byte;
  logic                  rw;
  logic [NREGS_LOG2-1:0] ptr;
  logic                  sda_q;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl (
    .sysclk (sysclk),
    .reset  (reset),
    .pin    (bus.scl_i),
    .level  (scl_f),
    .rise   (scl_rise),
    .fall   (scl_fall)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda (
    .sysclk (sysclk),
    .reset  (reset),
    .pin    (bus.sda_i),
    .level  (sda_f),
    .rise   (sda_rise),
    .fall   (sda_fall)
  );

  assign cond_start = sda_fall && scl_f;
  assign cond_stop  = sda_rise && scl_f;
  assign rx_state   = (state == ADDR) || (state == PTR) || (state == WDATA);
  assign rx_byte    = {sr[6:0], sda_f};
  assign host_q     = regs[host_idx];
  assign bus.sda_o  = sda_q;

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state    <= IDLE;
      bitcnt   <= '0;
      sr       <= '0;
      tx       <= '1;
      rw       <= 1'b0;
      ptr      <= '0;
      sda_q    <= NACK;
      busy     <= 1'b0;
      wr_valid <= 1'b0;
      wr_data  <= '0;
      wr_idx   <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      wr_valid <= 1'b0;
      if (cond_start) begin
        bitcnt <= '0;
        sda_q  <= NACK;
        state  <= ADDR;
      end else if (cond_stop) begin
        sda_q <= NACK;
        busy  <= 1'b0;
        state <= IDLE;
      end else begin
        if (rx_state && scl_rise && bitcnt != BYTE_BITS) begin
          sr     <= rx_byte;
          bitcnt <= bitcnt + 1'b1;
        end
        unique case (state)
          ADDR: begin
            if (scl_fall && bitcnt == BYTE_BITS) begin
              if (sr[7:1] == ADDR7) begin
                sda_q <= ACK;
                busy  <= 1'b1;
                rw    <= sr[0];
                state <= ADDR_ACK;
              end else begin
                state <= IGNORE;
              end
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              if (rw) begin
                sda_q  <= regs[ptr][7];
                tx     <= {regs[ptr][6:0], 1'b1};
                bitcnt <= FIRST_TX;
                state  <= RDATA;
              end else begin
                sda_q  <= NACK;
                bitcnt <= '0;
                state  <= PTR;
              end
            end
          end
          PTR: begin
            if (scl_fall && bitcnt == BYTE_BITS) begin
              ptr   <= sr[NREGS_LOG2-1:0];
              sda_q <= ACK;
              state <= PTR_ACK;
            end
          end
          PTR_ACK, WDATA_ACK: begin
            if (scl_fall) begin
              sda_q  <= NACK;
              bitcnt <= '0;
              state  <= WDATA;
            end
          end
          WDATA: begin
            if (scl_rise && bitcnt == LAST_BIT) begin
              regs[ptr] <= rx_byte;
              wr_data   <= rx_byte;
              wr_idx    <= ptr;
              wr_valid  <= 1'b1;
              ptr       <= ptr + 1'b1;
            end
            if (scl_fall && bitcnt == BYTE_BITS) begin
              sda_q <= ACK;
              state <= WDATA_ACK;
            end
          end
          RDATA: begin
            if (scl_fall) begin
              if (bitcnt == BYTE_BITS) begin
                sda_q <= NACK;
                state <= RDATA_ACK;
              end else begin
                sda_q  <= tx[7];
                tx     <= {tx[6:0], 1'b1};
                bitcnt <= bitcnt + 1'b1;
              end
            end
          end
          RDATA_ACK: begin
            // entry was on a fall, so any fall seen here ends the ACK bit
            if (scl_rise) begin
              ptr <= ptr + 1'b1;
              if (sda_f == NACK) state <= IGNORE;
            end else if (scl_fall) begin
              sda_q  <= regs[ptr][7];
              tx     <= {regs[ptr][6:0], 1'b1};
              bitcnt <= FIRST_TX;
              state  <= RDATA;
            end
          end
          IDLE, IGNORE: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-level I2C host, table vectors,
// directed corner sequences and random transactions vs a register model.
module tb_i2c_target;

  localparam int Q = 8;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] ptr;
    logic [7:0] data;
    logic       ack;
    logic [3:0] idx;
  } vec_t;

  logic sysclk = 1'b0;
  logic reset = 1'b1;
  logic host_scl = 1'b1;
  logic host_sda = 1'b1;
  logic glitch = 1'b0;
  logic [3:0] host_idx = '0;
  logic [7:0] host_q;
  logic [7:0] wr_data;
  logic [3:0] wr_idx;
  logic wr_valid;
  logic busy;

  i2c_target_if bus();
  assign bus.scl_i = host_scl;
  assign bus.sda_i = host_sda & bus.sda_o;

  always #5 sysclk = ~sysclk;

  i2c_target dut (
    .sysclk   (sysclk),
    .reset    (reset),
    .bus      (bus),
    .host_idx (host_idx),
    .host_q   (host_q),
    .wr_data  (wr_data),
    .wr_idx   (wr_idx),
    .wr_valid (wr_valid),
    .busy     (busy)
  );

  int n_vec = 0;
  int n_err = 0;
  int wv_double = 0;
  logic wv_prev = 1'b0;
  logic sda_low_seen = 1'b0;
  logic busy_seen = 1'b0;

  logic [7:0] mregs [16];
  int mptr = 0;
  logic [11:0] exp_wr[$];
  logic [11:0] got_wr[$];
  logic [7:0] dbuf [8];
  vec_t tbl [6];

  always @(negedge sysclk) begin
    if (wr_valid) got_wr.push_back({wr_idx, wr_data});
    if (wr_valid && wv_prev) wv_double++;
    wv_prev = wr_valid;
    if (!bus.sda_o) sda_low_seen = 1'b1;
    if (busy) busy_seen = 1'b1;
  end

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  task automatic do_start();
    host_sda = 1'b1;
    tick(Q);
    host_scl = 1'b1;
    tick(2 * Q);
    host_sda = 1'b0;
    tick(2 * Q);
    host_scl = 1'b0;
    tick(Q);
  endtask

  task automatic do_stop();
    host_sda = 1'b0;
    tick(Q);
    host_scl = 1'b1;
    tick(2 * Q);
    host_sda = 1'b1;
    tick(2 * Q);
  endtask

  task automatic send_bit(input logic b, output logic r);
    host_sda = b;
    tick(Q);
    host_scl = 1'b1;
    tick(Q);
    r = bus.sda_i;
    if (glitch) begin
      host_scl = 1'b0;
      tick(1);
      host_scl = 1'b1;
      tick(Q - 1);
    end else begin
      tick(Q);
    end
    host_scl = 1'b0;
    if (glitch) begin
      tick(3);
      host_scl = 1'b1;
      tick(1);
      host_scl = 1'b0;
      tick(Q - 4);
    end else begin
      tick(Q);
    end
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) send_bit(b[i], r);
    send_bit(1'b1, r);
    ack = !r;
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] b);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, r);
      b[i] = r;
    end
    send_bit(!ack, r);
  endtask

  task automatic check_wr(input string nm);
    check({nm, " wr count"}, 32'(got_wr.size()), 32'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++)
      check({nm, " wr"}, 32'(got_wr[i]), 32'(exp_wr[i]));
    got_wr.delete();
    exp_wr.delete();
  endtask

  task automatic txn_write(input logic [7:0] p, input int n,
                           input string nm);
    logic a;
    do_start();
    write_byte(8'h72, a);
    check({nm, " addr ack"}, 32'(a), 32'(1));
    check({nm, " busy"}, 32'(busy), 32'(1));
    write_byte(p, a);
    check({nm, " ptr ack"}, 32'(a), 32'(1));
    mptr = int'(p) % 16;
    for (int i = 0; i < n; i++) begin
      write_byte(dbuf[i], a);
      check({nm, " data ack"}, 32'(a), 32'(1));
      mregs[mptr] = dbuf[i];
      exp_wr.push_back({4'(mptr), dbuf[i]});
      mptr = (mptr + 1) % 16;
    end
    do_stop();
    check({nm, " busy off"}, 32'(busy), 32'(0));
    check_wr(nm);
  endtask

  task automatic txn_read(input logic sp, input logic [7:0] p,
                          input int n, input string nm);
    logic a;
    logic [7:0] b;
    do_start();
    if (sp) begin
      write_byte(8'h72, a);
      check({nm, " waddr ack"}, 32'(a), 32'(1));
      write_byte(p, a);
      check({nm, " ptr ack"}, 32'(a), 32'(1));
      mptr = int'(p) % 16;
      do_start();
    end
    write_byte(8'h73, a);
    check({nm, " raddr ack"}, 32'(a), 32'(1));
    for (int i = 0; i < n; i++) begin
      read_byte(i != n - 1, b);
      check({nm, " rd"}, 32'(b), 32'(mregs[mptr]));
      mptr = (mptr + 1) % 16;
    end
    do_stop();
    check({nm, " busy off"}, 32'(busy), 32'(0));
  endtask

  task automatic nomatch(input logic [7:0] addr, input string nm);
    logic a;
    sda_low_seen = 1'b0;
    busy_seen = 1'b0;
    do_start();
    write_byte(addr, a);
    check({nm, " nack"}, 32'(a), 32'(0));
    write_byte(8'h00, a);
    do_stop();
    check({nm, " sda low"}, 32'(sda_low_seen), 32'(0));
    check({nm, " busy seen"}, 32'(busy_seen), 32'(0));
  endtask

  initial begin
    logic a;
    logic r;
    logic [7:0] ab;
    logic [6:0] a7;
    int kind;
    int n;

    for (int i = 0; i < 16; i++) mregs[i] = '0;

    tbl[0] = '{8'h72, 8'h00, 8'h1e, 1'b1, 4'h0};
    tbl[1] = '{8'h70, 8'h00, 8'h55, 1'b0, 4'h0};
    tbl[2] = '{8'h72, 8'h0f, 8'h11, 1'b1, 4'hf};
    tbl[3] = '{8'h72, 8'h13, 8'ha5, 1'b1, 4'h3};
    tbl[4] = '{8'h72, 8'h28, 8'h3c, 1'b1, 4'h8};
    tbl[5] = '{8'h74, 8'h05, 8'h99, 1'b0, 4'h0};

    tick(3);
    check("rst sda_o", 32'(bus.sda_o), 32'(1));
    check("rst busy", 32'(busy), 32'(0));
    check("rst wr_valid", 32'(wr_valid), 32'(0));
    check("rst wr_data", 32'(wr_data), 32'(0));
    check("rst wr_idx", 32'(wr_idx), 32'(0));
    reset = 1'b0;
    tick(4);
    host_idx = 4'd3;
    #1;
    check("rst reg3", 32'(host_q), 32'(0));

    for (int v = 0; v < 6; v++) begin
      got_wr.delete();
      if (tbl[v].ack) begin
        do_start();
        write_byte(tbl[v].addr, a);
        check("tbl addr ack", 32'(a), 32'(1));
        write_byte(tbl[v].ptr, a);
        check("tbl ptr ack", 32'(a), 32'(1));
        write_byte(tbl[v].data, a);
        check("tbl data ack", 32'(a), 32'(1));
        do_stop();
        check("tbl wr count", 32'(got_wr.size()), 32'(1));
        if (got_wr.size() > 0)
          check("tbl wr", 32'(got_wr[0]), 32'({tbl[v].idx, tbl[v].data}));
        host_idx = tbl[v].idx;
        #1;
        check("tbl host_q", 32'(host_q), 32'(tbl[v].data));
        mregs[tbl[v].idx] = tbl[v].data;
      end else begin
        nomatch(tbl[v].addr, "tbl nomatch");
        check("tbl no wr", 32'(got_wr.size()), 32'(0));
      end
      got_wr.delete();
    end

    dbuf[0] = 8'h1e; dbuf[1] = 8'hbb; dbuf[2] = 8'h27;
    txn_write(8'h00, 3, "w3");
    host_idx = 4'd2;
    #1;
    check("w3 host_q2", 32'(host_q), 32'(8'h27));

    dbuf[0] = 8'ha1; dbuf[1] = 8'hb2; dbuf[2] = 8'hc3;
    txn_write(8'h05, 3, "pre567");
    txn_read(1'b1, 8'h05, 2, "rd56");
    txn_read(1'b0, 8'h00, 1, "ptr7");

    nomatch(8'h70, "nm70");
    dbuf[0] = 8'h42;
    txn_write(8'h09, 1, "after nm");

    dbuf[0] = 8'h11; dbuf[1] = 8'h22;
    txn_write(8'h0f, 2, "wrap");
    host_idx = 4'hf;
    #1;
    check("wrap regf", 32'(host_q), 32'(8'h11));
    host_idx = 4'h0;
    #1;
    check("wrap reg0", 32'(host_q), 32'(8'h22));

    glitch = 1'b1;
    dbuf[0] = 8'ha5; dbuf[1] = 8'h5a;
    txn_write(8'h04, 2, "glitch");
    glitch = 1'b0;
    txn_read(1'b1, 8'h04, 2, "glitch rd");

    ab = 8'h72;
    do_start();
    for (int i = 7; i >= 0; i--) send_bit(ab[i], r);
    check("mid ack drive", 32'(bus.sda_o), 32'(0));
    reset = 1'b1;
    tick(1);
    check("mid rst sda", 32'(bus.sda_o), 32'(1));
    check("mid rst busy", 32'(busy), 32'(0));
    reset = 1'b0;
    for (int i = 0; i < 16; i++) mregs[i] = '0;
    mptr = 0;
    got_wr.delete();
    exp_wr.delete();
    host_idx = 4'h0;
    #1;
    check("mid rst reg0", 32'(host_q), 32'(0));
    tick(Q);
    do_stop();
    dbuf[0] = 8'h6d;
    txn_write(8'h02, 1, "post rst");

    for (int t = 0; t < 20; t++) begin
      kind = int'($urandom_range(0, 9));
      n = int'($urandom_range(1, 3));
      for (int i = 0; i < n; i++) dbuf[i] = 8'($urandom_range(0, 255));
      if (kind < 1) begin
        a7 = 7'($urandom_range(0, 127));
        if (a7 == 7'h39) a7 = 7'h3a;
        nomatch({a7, 1'($urandom_range(0, 1))}, "rnd nomatch");
      end else if (kind < 5) begin
        txn_write(8'($urandom_range(0, 255)), n, "rnd wr");
      end else if (kind < 8) begin
        txn_read(1'b1, 8'($urandom_range(0, 255)), n, "rnd rdp");
      end else begin
        txn_read(1'b0, 8'h00, n, "rnd rd");
      end
    end

    check("wr_valid width", 32'(wv_double), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
